// File: rtl/vga_bounce_module.sv
// vga_bounce_module: RGB565 pixel stage that draws a square bouncing off the
// edges of a 640x480 active area, advancing once per frame on the VSYNC edge.
// RGB, HSYNC and VSYNC leave through one register stage so they stay aligned.
// Optional build macro: GRID_OVERLAY_EN draws a grey 64-pixel grid behind the box.
module vga_bounce_module #(
   parameter int unsigned H_ACT = 640,
   parameter int unsigned V_ACT = 480,
   parameter int unsigned BOX   = 32,
   parameter int unsigned STEP  = 2
) (
   input  logic        CLK,
   input  logic        RST_n,
   input  logic        Ready_Sig,
   input  logic [10:0] Column_Addr_Sig,
   input  logic [10:0] Row_Addr_Sig,
   input  logic        HSYNC_Sig,
   input  logic        VSYNC_Sig,
   input  logic        Pause_Sig,
   output logic [4:0]  Red_Sig,
   output logic [5:0]  Green_Sig,
   output logic [4:0]  Blue_Sig,
   output logic        HSYNC_Out,
   output logic        VSYNC_Out
);

   localparam int unsigned AW = 11;
   localparam int unsigned CW = 12;

   // bit 1: x heading left, bit 0: y heading up
   typedef enum logic [1:0] {
      DR = 2'b00,
      UR = 2'b01,
      DL = 2'b10,
      UL = 2'b11
   } motion_t;

   motion_t        state, state_nxt;
   logic [AW-1:0]  box_x, box_y, box_x_nxt, box_y_nxt;
   logic [1:0]     colour_idx, colour_nxt;
   logic           vs_d;
   logic           tick_c;
   logic           rev_x, rev_y;
   logic [CW-1:0]  x12, y12, col12, row12;
   logic           inbox_c;
   logic [15:0]    box_rgb, bg_rgb, pix_nxt;

   assign tick_c = VSYNC_Sig & ~vs_d;

   // Next position, direction and colour for the coming frame tick
   always_comb begin
      box_x_nxt  = box_x;
      box_y_nxt  = box_y;
      rev_x      = 1'b0;
      rev_y      = 1'b0;
      colour_nxt = colour_idx;
      x12        = CW'(box_x);
      y12        = CW'(box_y);

      if (!state[1]) begin
         if (x12 + CW'(BOX + STEP) > CW'(H_ACT)) begin
            box_x_nxt = AW'(H_ACT - BOX);
            rev_x     = 1'b1;
         end else begin
            box_x_nxt = box_x + AW'(STEP);
         end
      end else begin
         if (x12 < CW'(STEP)) begin
            box_x_nxt = '0;
            rev_x     = 1'b1;
         end else begin
            box_x_nxt = box_x - AW'(STEP);
         end
      end

      if (!state[0]) begin
         if (y12 + CW'(BOX + STEP) > CW'(V_ACT)) begin
            box_y_nxt = AW'(V_ACT - BOX);
            rev_y     = 1'b1;
         end else begin
            box_y_nxt = box_y + AW'(STEP);
         end
      end else begin
         if (y12 < CW'(STEP)) begin
            box_y_nxt = '0;
            rev_y     = 1'b1;
         end else begin
            box_y_nxt = box_y - AW'(STEP);
         end
      end

      state_nxt = motion_t'({state[1] ^ rev_x, state[0] ^ rev_y});

      // a corner hit reverses both axes but still advances the colour once
      if (rev_x | rev_y)
         colour_nxt = (colour_idx == 2'd2) ? 2'd0 : colour_idx + 2'd1;
   end

   // Motion FSM: position, direction and colour advance on an unpaused tick
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state      <= DR;
         box_x      <= '0;
         box_y      <= '0;
         colour_idx <= 2'd0;
         vs_d       <= 1'b1;
      end else begin
         vs_d <= VSYNC_Sig;
         if (tick_c && !Pause_Sig) begin
            state      <= state_nxt;
            box_x      <= box_x_nxt;
            box_y      <= box_y_nxt;
            colour_idx <= colour_nxt;
         end
      end
   end

   // Pixel classification against the current box position
   always_comb begin
      col12   = CW'(Column_Addr_Sig);
      row12   = CW'(Row_Addr_Sig);
      inbox_c = Ready_Sig
              & (col12 >= x12) & (col12 < x12 + CW'(BOX))
              & (row12 >= y12) & (row12 < y12 + CW'(BOX));

      case (colour_idx)
         2'd1:    box_rgb = 16'h07E0;
         2'd2:    box_rgb = 16'h001F;
         default: box_rgb = 16'hF800;
      endcase

`ifdef GRID_OVERLAY_EN
      if ((Column_Addr_Sig[5:0] == 6'd0) || (Row_Addr_Sig[5:0] == 6'd0))
         bg_rgb = 16'h4208;
      else
         bg_rgb = 16'h0000;
`else
      bg_rgb = 16'h0000;
`endif

      if (inbox_c)
         pix_nxt = box_rgb;
      else if (Ready_Sig)
         pix_nxt = bg_rgb;
      else
         pix_nxt = 16'h0000;
   end

   // Output stage: RGB and both syncs share one register delay
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         Red_Sig   <= '0;
         Green_Sig <= '0;
         Blue_Sig  <= '0;
         HSYNC_Out <= 1'b1;
         VSYNC_Out <= 1'b1;
      end else begin
         {Red_Sig, Green_Sig, Blue_Sig} <= pix_nxt;
         HSYNC_Out <= HSYNC_Sig;
         VSYNC_Out <= VSYNC_Sig;
      end
   end

endmodule

// File: tb/tb_vga_bounce_module.sv
// Bench for vga_bounce_module: directed steps with an independent motion model
// and a scoreboard queue for the one-cycle pixel/sync path.
module tb_vga_bounce_module;

   localparam int H_ACT = 640;
   localparam int V_ACT = 480;
   localparam int BOX   = 32;
   localparam int STEP  = 2;

   logic        CLK = 1'b0;
   logic        RST_n;
   logic        Ready_Sig;
   logic [10:0] Column_Addr_Sig;
   logic [10:0] Row_Addr_Sig;
   logic        HSYNC_Sig;
   logic        VSYNC_Sig;
   logic        Pause_Sig;
   logic [4:0]  Red_Sig;
   logic [5:0]  Green_Sig;
   logic [4:0]  Blue_Sig;
   logic        HSYNC_Out;
   logic        VSYNC_Out;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int   mx, my, mcol, n_mov;
   logic mdx, mdy;

   typedef struct {
      logic [15:0] rgb;
      logic        hs;
      logic        vs;
      string       tag;
   } exp_t;
   exp_t sb[$];

   vga_bounce_module dut (
      .CLK             (CLK),
      .RST_n           (RST_n),
      .Ready_Sig       (Ready_Sig),
      .Column_Addr_Sig (Column_Addr_Sig),
      .Row_Addr_Sig    (Row_Addr_Sig),
      .HSYNC_Sig       (HSYNC_Sig),
      .VSYNC_Sig       (VSYNC_Sig),
      .Pause_Sig       (Pause_Sig),
      .Red_Sig         (Red_Sig),
      .Green_Sig       (Green_Sig),
      .Blue_Sig        (Blue_Sig),
      .HSYNC_Out       (HSYNC_Out),
      .VSYNC_Out       (VSYNC_Out)
   );

   always #5 CLK = ~CLK;

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] colour_of(input int idx);
      case (idx)
         0:       return 16'hF800;
         1:       return 16'h07E0;
         default: return 16'h001F;
      endcase
   endfunction

   function automatic logic [15:0] bg_of(input int c, input int r);
`ifdef GRID_OVERLAY_EN
      if ((c % 64) == 0 || (r % 64) == 0) return 16'h4208;
`endif
      return 16'h0000;
   endfunction

   function automatic logic [15:0] exp_pix(input logic rdy, input int c, input int r);
      if (!rdy) return 16'h0000;
      if (c >= mx && c < mx + BOX && r >= my && r < my + BOX) return colour_of(mcol);
      return bg_of(c, r);
   endfunction

   task automatic model_reset();
      mx = 0; my = 0; mdx = 1'b0; mdy = 1'b0; mcol = 0;
   endtask

   // one motion step of the reference model; reports which axes bounced
   task automatic model_step(output logic rx, output logic ry);
      rx = 1'b0; ry = 1'b0;
      if (!mdx) begin
         if (mx + BOX + STEP > H_ACT) begin mx = H_ACT - BOX; mdx = 1'b1; rx = 1'b1; end
         else mx = mx + STEP;
      end else begin
         if (mx < STEP) begin mx = 0; mdx = 1'b0; rx = 1'b1; end
         else mx = mx - STEP;
      end
      if (!mdy) begin
         if (my + BOX + STEP > V_ACT) begin my = V_ACT - BOX; mdy = 1'b1; ry = 1'b1; end
         else my = my + STEP;
      end else begin
         if (my < STEP) begin my = 0; mdy = 1'b0; ry = 1'b1; end
         else my = my - STEP;
      end
      if (rx || ry) mcol = (mcol + 1) % 3;
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".box_x"}, 32'(dut.box_x), 32'(mx));
      chk({tag, ".box_y"}, 32'(dut.box_y), 32'(my));
      chk({tag, ".state"}, 32'(dut.state), 32'({mdx, mdy}));
      chk({tag, ".colour"}, 32'(dut.colour_idx), 32'(mcol));
   endtask

   // one VSYNC low pulse; the rising edge is the frame tick
   task automatic do_tick(output logic rx, output logic ry);
      rx = 1'b0; ry = 1'b0;
      VSYNC_Sig = 1'b0;
      cyc();
      VSYNC_Sig = 1'b1;
      cyc();
      if (!Pause_Sig) begin
         model_step(rx, ry);
         n_mov++;
      end
   endtask

   // drive one pixel/sync sample, queue its expectation, compare one cycle later
   task automatic pix(input string tag, input logic rdy, input int c, input int r,
                      input logic hs, input logic vs);
      exp_t e, got;
      Ready_Sig       = rdy;
      Column_Addr_Sig = 11'(c);
      Row_Addr_Sig    = 11'(r);
      HSYNC_Sig       = hs;
      VSYNC_Sig       = vs;
      e.rgb = exp_pix(rdy, c, r);
      e.hs  = hs;
      e.vs  = vs;
      e.tag = tag;
      sb.push_back(e);
      cyc();
      got = sb.pop_front();
      chk({got.tag, ".rgb"}, 32'({Red_Sig, Green_Sig, Blue_Sig}), 32'(got.rgb));
      chk({got.tag, ".hs"}, 32'(HSYNC_Out), 32'(got.hs));
      chk({got.tag, ".vs"}, 32'(VSYNC_Out), 32'(got.vs));
   endtask

   initial begin
      logic rx, ry;
      int   c0, x0, y0;
      bit   corner_seen;

      RST_n = 1'b0; Ready_Sig = 1'b0; Column_Addr_Sig = '0; Row_Addr_Sig = '0;
      HSYNC_Sig = 1'b1; VSYNC_Sig = 1'b1; Pause_Sig = 1'b0;
      model_reset();
      n_mov = 0;
      repeat (3) cyc();

      // reset values
      chk("rst.rgb", 32'({Red_Sig, Green_Sig, Blue_Sig}), 32'h0);
      chk("rst.hs", 32'(HSYNC_Out), 32'h1);
      chk("rst.vs", 32'(VSYNC_Out), 32'h1);
      check_state("rst");

      // release with VSYNC high: no spurious tick
      RST_n = 1'b1;
      repeat (4) cyc();
      check_state("no_spurious");

      // first tick
      do_tick(rx, ry);
      chk("tick1.box_x", 32'(dut.box_x), 32'd2);
      chk("tick1.box_y", 32'(dut.box_y), 32'd2);
      check_state("tick1");

      // move to (50,50) and probe the pixel path
      while (n_mov < 25) do_tick(rx, ry);
      check_state("t25");
      pix("pix_in_tl", 1'b1, mx, my, 1'b1, 1'b1);
      pix("pix_in_br", 1'b1, mx + BOX - 1, my + BOX - 1, 1'b1, 1'b1);
      pix("pix_right", 1'b1, mx + BOX, my, 1'b1, 1'b1);
      pix("pix_left", 1'b1, mx - 1, my, 1'b1, 1'b1);
      pix("pix_below", 1'b1, mx, my + BOX, 1'b1, 1'b1);
      pix("pix_grid", 1'b1, 64, 10, 1'b1, 1'b1);
      pix("pix_grid_bg", 1'b1, 65, 11, 1'b1, 1'b1);
      pix("pix_noready", 1'b0, mx, my, 1'b1, 1'b1);

      // sync alignment, paused so the VSYNC pulse does not move the box
      Pause_Sig = 1'b1;
      pix("sync_h0", 1'b1, mx, my, 1'b0, 1'b1);
      pix("sync_v0", 1'b0, 0, 0, 1'b1, 1'b0);
      pix("sync_v1", 1'b0, 0, 0, 1'b1, 1'b1);
      Pause_Sig = 1'b0;
      check_state("sync_paused");

      // right edge approach: 606 -> 608 -> 608 and reverse
      while (n_mov < 303) do_tick(rx, ry);
      chk("x606", 32'(dut.box_x), 32'd606);
      chk("x606.dir", 32'(dut.state[1]), 32'd0);
      c0 = mcol;
      do_tick(rx, ry);
      chk("x608a", 32'(dut.box_x), 32'd608);
      chk("x608a.dir", 32'(dut.state[1]), 32'd0);
      chk("x608a.col", 32'(dut.colour_idx), 32'(c0));
      do_tick(rx, ry);
      chk("x608b", 32'(dut.box_x), 32'd608);
      chk("x608b.dir", 32'(dut.state[1]), 32'd1);
      chk("x608b.col", 32'(dut.colour_idx), 32'((c0 + 1) % 3));
      check_state("x608b");

      // pause across three ticks, then one step
      Pause_Sig = 1'b1;
      x0 = mx; y0 = my; c0 = mcol;
      repeat (3) do_tick(rx, ry);
      chk("pause.x", 32'(dut.box_x), 32'(x0));
      chk("pause.y", 32'(dut.box_y), 32'(y0));
      chk("pause.col", 32'(dut.colour_idx), 32'(c0));
      Pause_Sig = 1'b0;
      do_tick(rx, ry);
      chk("unpause.x", 32'(dut.box_x), 32'(x0 - STEP));
      check_state("unpause");

      // run until the model sees a corner bounce (bottom-right, both axes)
      corner_seen = 1'b0;
      while (!corner_seen && n_mov < 20000) begin
         c0 = mcol;
         do_tick(rx, ry);
         if (rx && ry) corner_seen = 1'b1;
         if ((n_mov % 500) == 0) check_state("run");
      end
      chk("corner.reached", 32'(corner_seen), 32'd1);
      chk("corner.box_x", 32'(dut.box_x), 32'(H_ACT - BOX));
      chk("corner.box_y", 32'(dut.box_y), 32'(V_ACT - BOX));
      chk("corner.state", 32'(dut.state), 32'b11);
      chk("corner.col", 32'(dut.colour_idx), 32'((c0 + 1) % 3));
      check_state("corner");

      // asynchronous reset mid-line with a box pixel in the output register
      pix("pre_rst", 1'b1, mx, my, 1'b1, 1'b1);
      Ready_Sig = 1'b1; HSYNC_Sig = 1'b0;
      #2;
      RST_n = 1'b0;
      #1;
      chk("arst.rgb", 32'({Red_Sig, Green_Sig, Blue_Sig}), 32'h0);
      chk("arst.hs", 32'(HSYNC_Out), 32'h1);
      chk("arst.vs", 32'(VSYNC_Out), 32'h1);
      model_reset();
      check_state("arst");
      repeat (2) cyc();
      Ready_Sig = 1'b0; HSYNC_Sig = 1'b1; VSYNC_Sig = 1'b1;
      RST_n = 1'b1;
      repeat (3) cyc();
      check_state("arst_release");
      do_tick(rx, ry);
      chk("arst_tick.box_x", 32'(dut.box_x), 32'd2);
      chk("arst_tick.box_y", 32'(dut.box_y), 32'd2);
      check_state("arst_tick");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
